mbtrain_sb_arbiter: RTL and testbench
=====================================

# mbtrain_sb_arbiter

Shares the single sideband transmit path between the two halves of an MBTRAIN substate pair: the TX-side initiator FSM (start/end requests) and the RX-side responder FSM (start/end responses). Each requester raises a level valid with a 4-bit decoded message. The arbiter latches it, issues it to the sideband serializer as a one-cycle launch, tracks serializer busy, and returns a per-requester done pulse on the busy falling edge. Fair round-robin ordering prevents a responder from starving the initiator, or the reverse, when both fire in the same window.

## Interface
- MSG_W, 4, decoded sideband message width
- TIMEOUT_CYC, 16, max cycles from launch to i_sb_busy rising before abort (≥2)
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- i_en  in  1  substate enable; low = flush/abort
- i_tx_valid  in  1  initiator request level
- i_tx_msg  in  MSG_W  initiator message
- i_rx_valid  in  1  responder request level
- i_rx_msg  in  MSG_W  responder message
- i_sb_busy  in  1  serializer busy level
- o_sb_valid  out  1  one-cycle launch strobe to serializer
- o_sb_msg  out  MSG_W  launched message, held until next launch
- o_sb_src  out  1  source of launched message: 0 = tx, 1 = rx
- o_tx_done, o_rx_done  out  1  one-cycle completion pulse per source
- o_tx_pending, o_rx_pending  out  1  message latched, not yet launched
- o_drop  out  1  one-cycle pulse: pending message overwritten
- o_timeout  out  1  one-cycle pulse: serializer never went busy

## Operation
- Capture, per requester:
  - On a valid rising edge (sampled high now, low last cycle) with i_en high, latch msg and set pending.
  - If pending is already set: overwrite msg (latest wins) and pulse o_drop.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE: if any pending and ~i_sb_busy, select a source and go to LAUNCH.
  - Only one pending: select it.
  - Both pending: select the source not granted last (last_grant resets to rx, so tx wins the first tie).
- LAUNCH (one cycle):
  - o_sb_valid=1; o_sb_msg/o_sb_src loaded.
  - Clear the selected pending; update last_grant.
  - Go to WAIT_BUSY and clear the timeout counter.
- WAIT_BUSY: i_sb_busy high → WAIT_DONE. Otherwise the counter increments; on reaching TIMEOUT_CYC, pulse o_timeout and the granted source's done pulse, then go to IDLE.
- WAIT_DONE: busy falling edge (busy_q & ~i_sb_busy) → granted source's done pulse, then IDLE.
- i_en low, any state:
  - Next state IDLE; both pendings cleared; o_sb_valid forced 0.
  - No done/timeout pulse; counter cleared.
  - Rising edges are not captured while i_en is low.

## Timing
- Reset values: all outputs 0, o_sb_msg=0, cs=IDLE, pendings 0, busy_q 0, last_grant=rx.
- Launch latency:
  - Valid rising sampled at edge k → pending high after k.
  - Select at edge k+1 → o_sb_valid high for the cycle after edge k+2 (arbiter idle, busy low).
- Done pulse: the cycle after the edge on which the busy falling edge is sampled.
- Back-to-back: earliest next o_sb_valid is 2 cycles after a done pulse (IDLE select, then LAUNCH).
- Capture in the same cycle that the same source's pending clears in LAUNCH: the new message stays pending (set dominates clear); the launched message is the old one.
- Both rising edges in the same cycle: both capture; tie rule applies.
- i_en falling in the same cycle as the busy falling edge: i_en wins, no done.
- i_sb_busy already high in IDLE: no launch until it falls.
- Async reset mid-transfer: immediate return to reset values; no pulses.

## Structure
- Shared package mbtrain_pkg holds:
  - state encodings;
  - SRC_TX=0 and SRC_RX=1;
  - MSG_W default;
  - the decoded message constants used by requesters: START_REQ=4'b0001, START_RESP=4'b0010, END_REQ=4'b0011, END_RESP=4'b0100.
- One natural sub-module, sb_req_latch: a rising-edge detector plus pending/message register with overwrite flag. Instantiate it twice.
- Arbitration, FSM, timeout counter and busy edge detector are top level.

## Test plan
- Single tx: i_tx_valid rises with msg 0x1. Required: o_sb_valid pulse 2 cycles later, o_sb_msg=0x1, o_sb_src=0. Busy high 5 cycles then low → one o_tx_done pulse, o_rx_done stays 0.
- Simultaneous: tx 0x3 and rx 0x2 rise together after reset. Required: tx launches first, rx launches 2 cycles after o_tx_done. Repeat the tie → rx first.
- Overwrite: tx 0x1 pending while busy is held high externally; tx drops and rises again with 0x3. Required: o_drop pulse, single launch of 0x3.
- Timeout: launch rx 0x4, busy never rises. Required: o_timeout and o_rx_done pulse exactly TIMEOUT_CYC cycles after WAIT_BUSY entry; FSM back in IDLE.
- Abort: i_en drops during WAIT_DONE with rx pending. Required: no done pulse, pendings 0, no further o_sb_valid. Re-enable + new tx rise → normal launch.
- Reset mid-transfer: rst_n pulsed low in WAIT_DONE. Required: all outputs 0 immediately; a following busy falling edge gives no done pulse.

Source files
------------

// File: rtl/mbtrain_sb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mbtrain_pkg
// Description : Shared types and constants for the MBTRAIN sideband arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package mbtrain_pkg;

    localparam int MSG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sb_state_e;

    localparam logic SRC_TX = 1'b0;
    localparam logic SRC_RX = 1'b1;

    localparam logic [MSG_W-1:0] START_REQ  = 4'b0001;
    localparam logic [MSG_W-1:0] START_RESP = 4'b0010;
    localparam logic [MSG_W-1:0] END_REQ    = 4'b0011;
    localparam logic [MSG_W-1:0] END_RESP   = 4'b0100;

    // Round-robin pick: on a tie the source not granted last time wins.
    function automatic logic rr_pick(input logic tx_p, input logic rx_p, input logic last);
        if (tx_p && rx_p) return (last == SRC_RX) ? SRC_TX : SRC_RX;
        if (tx_p)         return SRC_TX;
        return SRC_RX;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mbtrain_sb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mbtrain_sb_arbiter_if
// Description : Requester / serializer bundle around the sideband arbiter.
// Revision    : 1.0  initial release
// ============================================================================
interface mbtrain_sb_arbiter_if #(
    parameter int MSG_W = mbtrain_pkg::MSG_W
) ();
    logic             i_en;
    logic             i_tx_valid;
    logic [MSG_W-1:0] i_tx_msg;
    logic             i_rx_valid;
    logic [MSG_W-1:0] i_rx_msg;
    logic             i_sb_busy;
    logic             o_sb_valid;
    logic [MSG_W-1:0] o_sb_msg;
    logic             o_sb_src;
    logic             o_tx_done;
    logic             o_rx_done;
    logic             o_tx_pending;
    logic             o_rx_pending;
    logic             o_drop;
    logic             o_timeout;

    modport master (
        output i_en, i_tx_valid, i_tx_msg, i_rx_valid, i_rx_msg, i_sb_busy,
        input  o_sb_valid, o_sb_msg, o_sb_src, o_tx_done, o_rx_done,
               o_tx_pending, o_rx_pending, o_drop, o_timeout
    );

    modport slave (
        input  i_en, i_tx_valid, i_tx_msg, i_rx_valid, i_rx_msg, i_sb_busy,
        output o_sb_valid, o_sb_msg, o_sb_src, o_tx_done, o_rx_done,
               o_tx_pending, o_rx_pending, o_drop, o_timeout
    );
endinterface
`default_nettype wire

// File: rtl/mbtrain_sb_arbiter_sb_req_latch.sv
`default_nettype none
// ============================================================================
// Module      : sb_req_latch
// Description : Valid rising-edge capture into a pending/message register.
// Revision    : 1.0  initial release
// ============================================================================
module sb_req_latch #(
    parameter int MSG_W = 4
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              i_en,
    input  wire              i_valid,
    input  wire  [MSG_W-1:0] i_msg,
    input  wire              i_clr,
    output logic             o_pending,
    output logic [MSG_W-1:0] o_msg,
    output logic             o_drop
);
    logic r_valid_q;
    logic w_rise;

    assign w_rise = i_valid & ~r_valid_q & i_en;

    // A capture coinciding with the launch clear keeps the new message pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= 1'b0;
            o_pending <= 1'b0;
            o_msg     <= '0;
            o_drop    <= 1'b0;
        end else begin
            r_valid_q <= i_valid;
            o_drop    <= w_rise & o_pending & ~i_clr;
            if (w_rise) o_msg <= i_msg;
            if (!i_en)        o_pending <= 1'b0;
            else if (w_rise)  o_pending <= 1'b1;
            else if (i_clr)   o_pending <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mbtrain_sb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mbtrain_sb_arbiter
// Description : Round-robin share of the sideband TX path between the MBTRAIN
//               initiator and responder, with launch/busy/done tracking.
// Revision    : 1.0  initial release
// ============================================================================
module mbtrain_sb_arbiter
    import mbtrain_pkg::*;
#(
    parameter int MSG_W       = mbtrain_pkg::MSG_W,
    parameter int TIMEOUT_CYC = 16
) (
    input wire                   clk,
    input wire                   rst_n,
    mbtrain_sb_arbiter_if.slave  sb
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    sb_state_e        r_cs, w_ns;
    logic             r_sel, w_sel, r_last, r_busy_q;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tx_pend, w_rx_pend, w_tx_drop, w_rx_drop;
    logic [MSG_W-1:0] w_tx_msg, w_rx_msg;
    logic             w_launch, w_tx_clr, w_rx_clr, w_done, w_timeout;
    logic             w_cnt_clr, w_cnt_inc;
    logic             r_sb_valid, r_sb_src, r_tx_done, r_rx_done, r_timeout;
    logic [MSG_W-1:0] r_sb_msg;

    sb_req_latch #(.MSG_W(MSG_W)) u_tx_latch (
        .clk(clk), .rst_n(rst_n), .i_en(sb.i_en), .i_valid(sb.i_tx_valid),
        .i_msg(sb.i_tx_msg), .i_clr(w_tx_clr),
        .o_pending(w_tx_pend), .o_msg(w_tx_msg), .o_drop(w_tx_drop)
    );

    sb_req_latch #(.MSG_W(MSG_W)) u_rx_latch (
        .clk(clk), .rst_n(rst_n), .i_en(sb.i_en), .i_valid(sb.i_rx_valid),
        .i_msg(sb.i_rx_msg), .i_clr(w_rx_clr),
        .o_pending(w_rx_pend), .o_msg(w_rx_msg), .o_drop(w_rx_drop)
    );

    always_comb begin
        w_ns      = r_cs;
        w_sel     = r_sel;
        w_launch  = 1'b0;
        w_tx_clr  = 1'b0;
        w_rx_clr  = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        case (r_cs)
            ST_IDLE: begin
                if ((w_tx_pend | w_rx_pend) & ~sb.i_sb_busy) begin
                    w_sel = rr_pick(w_tx_pend, w_rx_pend, r_last);
                    w_ns  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_launch  = 1'b1;
                w_tx_clr  = (r_sel == SRC_TX);
                w_rx_clr  = (r_sel == SRC_RX);
                w_cnt_clr = 1'b1;
                w_ns      = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (sb.i_sb_busy) begin
                    w_ns = ST_WAIT_DONE;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_timeout = 1'b1;
                    w_done    = 1'b1;
                    w_ns      = ST_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (r_busy_q & ~sb.i_sb_busy) begin
                    w_done = 1'b1;
                    w_ns   = ST_IDLE;
                end
            end
            default: w_ns = ST_IDLE;
        endcase
        // Disable aborts whatever is in flight without reporting completion.
        if (!sb.i_en) begin
            w_ns      = ST_IDLE;
            w_launch  = 1'b0;
            w_tx_clr  = 1'b0;
            w_rx_clr  = 1'b0;
            w_done    = 1'b0;
            w_timeout = 1'b0;
            w_cnt_clr = 1'b1;
            w_cnt_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs       <= ST_IDLE;
            r_sel      <= SRC_TX;
            r_last     <= SRC_RX;
            r_busy_q   <= 1'b0;
            r_cnt      <= '0;
            r_sb_valid <= 1'b0;
            r_sb_msg   <= '0;
            r_sb_src   <= 1'b0;
            r_tx_done  <= 1'b0;
            r_rx_done  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_cs       <= w_ns;
            r_sel      <= w_sel;
            r_busy_q   <= sb.i_sb_busy;
            r_sb_valid <= w_launch;
            r_tx_done  <= w_done & (r_sel == SRC_TX);
            r_rx_done  <= w_done & (r_sel == SRC_RX);
            r_timeout  <= w_timeout;
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
            if (w_launch) begin
                r_last   <= r_sel;
                r_sb_src <= r_sel;
                r_sb_msg <= (r_sel == SRC_TX) ? w_tx_msg : w_rx_msg;
            end
        end
    end

    assign sb.o_sb_valid   = r_sb_valid;
    assign sb.o_sb_msg     = r_sb_msg;
    assign sb.o_sb_src     = r_sb_src;
    assign sb.o_tx_done    = r_tx_done;
    assign sb.o_rx_done    = r_rx_done;
    assign sb.o_tx_pending = w_tx_pend;
    assign sb.o_rx_pending = w_rx_pend;
    assign sb.o_drop       = w_tx_drop | w_rx_drop;
    assign sb.o_timeout    = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_mbtrain_sb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbtrain_sb_arbiter
// Description : Directed vector table plus corner sequences for the arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mbtrain_sb_arbiter;
    localparam int T = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;

    mbtrain_sb_arbiter_if #(.MSG_W(4)) sb ();

    mbtrain_sb_arbiter #(.MSG_W(4), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n), .sb(sb)
    );

    always #5 clk = ~clk;

    // Packed view: {valid, msg[3:0], src, tx_done, rx_done, tx_pend, rx_pend, drop, timeout}
    logic [11:0] w_act;
    assign w_act = {sb.o_sb_valid, sb.o_sb_msg, sb.o_sb_src, sb.o_tx_done, sb.o_rx_done,
                    sb.o_tx_pending, sb.o_rx_pending, sb.o_drop, sb.o_timeout};

    typedef struct {
        logic       txv;
        logic [3:0] txm;
        logic       rxv;
        logic [3:0] rxm;
        logic       busy;
        logic [11:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [11:0] op(int v, int m, int s, int td, int rd, int tp, int rp, int dr, int to);
        return {1'(v), 4'(m), 1'(s), 1'(td), 1'(rd), 1'(tp), 1'(rp), 1'(dr), 1'(to)};
    endfunction

    function automatic vec_t mk(int txv, int txm, int rxv, int rxm, int busy,
                                int v, int m, int s, int td, int rd, int tp, int rp, int dr, int to);
        vec_t r;
        r.txv  = 1'(txv);
        r.txm  = 4'(txm);
        r.rxv  = 1'(rxv);
        r.rxm  = 4'(rxm);
        r.busy = 1'(busy);
        r.exp  = op(v, m, s, td, rd, tp, rp, dr, to);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic txv, input logic [3:0] txm,
                         input logic rxv, input logic [3:0] rxm, input logic busy);
        sb.i_en       = en;
        sb.i_tx_valid = txv;
        sb.i_tx_msg   = txm;
        sb.i_rx_valid = rxv;
        sb.i_rx_msg   = rxm;
        sb.i_sb_busy  = busy;
    endtask

    task automatic chk(input string name, input logic [11:0] exp);
        n_vec++;
        if (w_act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b required %b (v,msg,src,tdone,rdone,tpend,rpend,drop,tout)",
                     name, w_act, exp);
        end
    endtask

    initial begin
        // simultaneous tie after reset: tx first, rx two cycles after tx done
        vq.push_back(mk(1,3,1,2,0, 0,0,0,0,0,1,1,0,0));
        vq.push_back(mk(1,3,1,2,0, 0,0,0,0,0,1,1,0,0));
        vq.push_back(mk(1,3,1,2,0, 1,3,0,0,0,0,1,0,0));
        vq.push_back(mk(0,0,0,0,1, 0,3,0,0,0,0,1,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,3,0,1,0,0,1,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,3,0,0,0,0,1,0,0));
        vq.push_back(mk(0,0,0,0,0, 1,2,1,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,1, 0,2,1,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,2,1,0,1,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,2,1,0,0,0,0,0,0));
        // single tx 0x1, busy five cycles
        vq.push_back(mk(1,1,0,0,0, 0,2,1,0,0,1,0,0,0));
        vq.push_back(mk(1,1,0,0,0, 0,2,1,0,0,1,0,0,0));
        vq.push_back(mk(1,1,0,0,0, 1,1,0,0,0,0,0,0,0));
        for (int i = 0; i < 5; i++) vq.push_back(mk(0,0,0,0,1, 0,1,0,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,1,0,1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,1,0,0,0,0,0,0,0));
        // tie again with tx granted last: rx first
        vq.push_back(mk(1,1,1,4,0, 0,1,0,0,0,1,1,0,0));
        vq.push_back(mk(1,1,1,4,0, 0,1,0,0,0,1,1,0,0));
        vq.push_back(mk(1,1,1,4,0, 1,4,1,0,0,1,0,0,0));
        vq.push_back(mk(0,0,0,0,1, 0,4,1,0,0,1,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,4,1,0,1,1,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,4,1,0,0,1,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 1,1,0,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,1, 0,1,0,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,1,0,1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,1,0,0,0,0,0,0,0));
        // overwrite while busy held high: drop, single launch of 0x3
        vq.push_back(mk(1,1,0,0,1, 0,1,0,0,0,1,0,0,0));
        vq.push_back(mk(0,0,0,0,1, 0,1,0,0,0,1,0,0,0));
        vq.push_back(mk(1,3,0,0,1, 0,1,0,0,0,1,0,1,0));
        vq.push_back(mk(1,3,0,0,1, 0,1,0,0,0,1,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,1,0,0,0,1,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 1,3,0,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,1, 0,3,0,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,3,0,1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,3,0,0,0,0,0,0,0));
        // capture during own LAUNCH: old message launched, new stays pending
        vq.push_back(mk(1,5,0,0,0, 0,3,0,0,0,1,0,0,0));
        vq.push_back(mk(0,5,0,0,0, 0,3,0,0,0,1,0,0,0));
        vq.push_back(mk(1,6,0,0,0, 1,5,0,0,0,1,0,0,0));
        vq.push_back(mk(0,0,0,0,1, 0,5,0,0,0,1,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,5,0,1,0,1,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,5,0,0,0,1,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 1,6,0,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,1, 0,6,0,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,6,0,1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,6,0,0,0,0,0,0,0));

        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        repeat (3) tick();
        chk("reset", op(0,0,0,0,0,0,0,0,0));
        rst_n = 1'b1;
        tick();
        chk("post_reset", op(0,0,0,0,0,0,0,0,0));

        foreach (vq[i]) begin
            drive(1'b1, vq[i].txv, vq[i].txm, vq[i].rxv, vq[i].rxm, vq[i].busy);
            tick();
            chk($sformatf("vec%0d", i), vq[i].exp);
        end

        // timeout: rx 0x4 launched, busy never rises
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'h4, 1'b0);
        tick(); chk("to_capture", op(0,6,0,0,0,0,1,0,0));
        tick(); chk("to_select",  op(0,6,0,0,0,0,1,0,0));
        tick(); chk("to_launch",  op(1,4,1,0,0,0,0,0,0));
        sb.i_rx_valid = 1'b0;
        for (int j = 1; j < T; j++) begin
            tick(); chk($sformatf("to_wait%0d", j), op(0,4,1,0,0,0,0,0,0));
        end
        tick(); chk("to_pulse", op(0,4,1,0,1,0,0,0,1));
        tick(); chk("to_after", op(0,4,1,0,0,0,0,0,0));
        drive(1'b1, 1'b1, 4'h3, 1'b0, 4'h0, 1'b0);
        tick(); chk("to_idle_cap", op(0,4,1,0,0,1,0,0,0));
        tick();
        tick(); chk("to_idle_launch", op(1,3,0,0,0,0,0,0,0));
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        tick();
        sb.i_sb_busy = 1'b0;
        tick(); chk("to_idle_done", op(0,3,0,1,0,0,0,0,0));
        tick();

        // abort in WAIT_DONE with rx pending; en falls with busy
        drive(1'b1, 1'b1, 4'h1, 1'b0, 4'h0, 1'b0);
        tick(); tick();
        tick(); chk("ab_launch", op(1,1,0,0,0,0,0,0,0));
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'h2, 1'b1);
        tick(); chk("ab_wait", op(0,1,0,0,0,0,1,0,0));
        tick(); chk("ab_wait2", op(0,1,0,0,0,0,1,0,0));
        sb.i_en = 1'b0;
        sb.i_sb_busy = 1'b0;
        tick(); chk("ab_abort", op(0,1,0,0,0,0,0,0,0));
        for (int j = 0; j < 4; j++) begin
            tick(); chk($sformatf("ab_quiet%0d", j), op(0,1,0,0,0,0,0,0,0));
        end
        sb.i_en = 1'b1;
        tick(); chk("ab_reen", op(0,1,0,0,0,0,0,0,0));
        sb.i_tx_valid = 1'b1;
        sb.i_tx_msg   = 4'h3;
        tick(); chk("ab_cap", op(0,1,0,0,0,1,0,0,0));
        tick();
        tick(); chk("ab_relaunch", op(1,3,0,0,0,0,0,0,0));
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        tick();
        sb.i_sb_busy = 1'b0;
        tick(); chk("ab_done", op(0,3,0,1,0,0,0,0,0));
        tick();

        // async reset during WAIT_DONE
        drive(1'b1, 1'b1, 4'h2, 1'b0, 4'h0, 1'b0);
        tick(); tick();
        tick(); chk("rs_launch", op(1,2,0,0,0,0,0,0,0));
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        tick(); chk("rs_busy", op(0,2,0,0,0,0,0,0,0));
        #2 rst_n = 1'b0;
        #1 chk("rs_async", op(0,0,0,0,0,0,0,0,0));
        tick(); chk("rs_held", op(0,0,0,0,0,0,0,0,0));
        rst_n = 1'b1;
        tick(); chk("rs_release", op(0,0,0,0,0,0,0,0,0));
        sb.i_sb_busy = 1'b0;
        tick(); chk("rs_nodone", op(0,0,0,0,0,0,0,0,0));
        tick(); chk("rs_nodone2", op(0,0,0,0,0,0,0,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
